// File: rtl/psram_opi_seq.sv
// psram_opi_seq: OPI DDR PSRAM transaction sequencer.
// Builds CE/SCK/IO waveform INST -> ADDR -> LATN -> WDATA/RDATA -> RECY.
// Ports: clk_i/rst_n_i (sync active-low), en_i, pscr_i (DIV4..DIV32),
//   req_* valid/ready request, wdata_* write stream, rdata_* read stream,
//   done_o/err_o pulses, busy_o/state_o status, psram_* pad signals.
// Optional macro PSRAM_DQS_EN: DQS-driven read capture and write DQS drive.
module psram_opi_seq #(
    parameter int LEN_W    = 16,
    parameter int RECY_CYC = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [1:0]       pscr_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_wr_i,
    input  logic [7:0]       req_cmd_i,
    input  logic [31:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       req_lc_i,
    input  logic [7:0]       wdata_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    output logic [7:0]       rdata_o,
    output logic             rdata_valid_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [2:0]       state_o,
    output logic             psram_sck_o,
    output logic             psram_ce_o,
    output logic [7:0]       psram_io_en_o,
    output logic [7:0]       psram_io_out_o,
    input  logic [7:0]       psram_io_in_i,
    output logic             psram_dqs_en_o,
    output logic             psram_dqs_out_o,
    input  logic             psram_dqs_in_i
);
    localparam int SW = (LEN_W > 9) ? LEN_W : 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INST  = 3'd1,
        S_ADDR  = 3'd2,
        S_LATN  = 3'd3,
        S_WDATA = 3'd4,
        S_RDATA = 3'd5,
        S_RECY  = 3'd6
    } state_e;

    state_e            state_q, state_d, data_st;
    logic [3:0]        cyc_q, cyc_d, hm1, hh;
    logic [SW-1:0]     slot_q, slot_d, nslot;
    logic              wr_q;
    logic [7:0]        cmd_q, lc_q;
    logic [31:0]       addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        pscr_q;
    logic [7:0]        wbyte_q, wbyte_d, rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, err_q, err_d;
    logic              accept, bad_req, active, slot_end, last_slot;

    assign req_ready_o = en_i && (state_q == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign bad_req     = (req_len_i == '0) || req_len_i[0] || req_addr_i[0];
    assign data_st     = wr_q ? S_WDATA : S_RDATA;

    // hm1 = H-1, hh = H/2 (slot cycle where SCK toggles)
    always_comb begin
        hm1 = 4'd1;
        unique case (pscr_q)
            2'b00: hm1 = 4'd1;
            2'b01: hm1 = 4'd3;
            2'b10: hm1 = 4'd7;
            2'b11: hm1 = 4'd15;
        endcase
    end
    assign hh = {1'b0, hm1[3:1]} + 4'd1;

    always_comb begin
        nslot = '0;
        unique case (state_q)
            S_INST:           nslot = SW'(2);
            S_ADDR:           nslot = SW'(4);
            S_LATN:           nslot = SW'({lc_q, 1'b0});
            S_WDATA, S_RDATA: nslot = SW'(len_q);
            default:          nslot = '0;
        endcase
    end

    assign slot_end  = (cyc_q == hm1);
    assign last_slot = (slot_q == nslot - SW'(1));

`ifdef PSRAM_DQS_EN
    logic [2:0]       dqs_q;
    logic             dqs_edge;
    logic [LEN_W-1:0] rcnt_q, rcnt_d;
    logic [LEN_W+5:0] tmo_q, tmo_d, tmo_lim;

    assign dqs_edge = dqs_q[1] ^ dqs_q[2];
    // 4*len*H with H = 2^(pscr+1)
    assign tmo_lim  = (LEN_W+6)'(len_q) << ({1'b0, pscr_q} + 3'd3);
`endif

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        slot_d        = slot_q;
        wbyte_d       = wbyte_q;
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        err_d         = 1'b0;
        wdata_ready_o = 1'b0;
`ifdef PSRAM_DQS_EN
        rcnt_d        = '0;
        tmo_d         = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_INST;
                        cyc_d   = '0;
                        slot_d  = '0;
                    end
                end
            end
            S_RECY: begin
                slot_d = slot_q + SW'(1);
                if (slot_q == SW'(RECY_CYC - 1)) begin
                    state_d = S_IDLE;
                    slot_d  = '0;
                end
            end
`ifdef PSRAM_DQS_EN
            S_RDATA: begin
                rcnt_d = rcnt_q;
                tmo_d  = tmo_q + 1'b1;
                cyc_d  = slot_end ? 4'd0 : cyc_q + 4'd1;
                if (slot_end) slot_d = slot_q + SW'(1);
                if (dqs_edge && (rcnt_q != len_q)) begin
                    rdata_d  = psram_io_in_i;
                    rvalid_d = 1'b1;
                    rcnt_d   = rcnt_q + 1'b1;
                end
                // leave only on an odd slot end so SCK parks low
                if (slot_end && slot_q[0] &&
                    ((rcnt_q == len_q) || (tmo_q >= tmo_lim))) begin
                    state_d = S_RECY;
                    slot_d  = '0;
                    err_d   = (rcnt_q != len_q);
                end
            end
`endif
            default: begin
                cyc_d = cyc_q + 4'd1;
                if (state_q == S_WDATA && cyc_q == 4'd0) begin
                    wdata_ready_o = 1'b1;
                    wbyte_d       = wdata_valid_i ? wdata_i : 8'h00;
                    err_d         = !wdata_valid_i;
                end
                if (state_q == S_RDATA && slot_end) begin
                    rdata_d  = psram_io_in_i;
                    rvalid_d = 1'b1;
                end
                if (slot_end) begin
                    cyc_d  = '0;
                    slot_d = slot_q + SW'(1);
                    if (last_slot) begin
                        slot_d = '0;
                        unique case (state_q)
                            S_INST:  state_d = S_ADDR;
                            S_ADDR:  state_d = (lc_q == 8'd0) ? data_st : S_LATN;
                            S_LATN:  state_d = data_st;
                            default: state_d = S_RECY;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            slot_q   <= '0;
            wr_q     <= 1'b0;
            cmd_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            lc_q     <= '0;
            pscr_q   <= '0;
            wbyte_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            slot_q   <= slot_d;
            wbyte_q  <= wbyte_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            if (accept) begin
                wr_q   <= req_wr_i;
                cmd_q  <= req_cmd_i;
                addr_q <= req_addr_i;
                len_q  <= req_len_i;
                lc_q   <= req_lc_i;
                pscr_q <= pscr_i;
            end
        end
    end

    assign active      = (state_q != S_IDLE) && (state_q != S_RECY);
    assign psram_ce_o  = !active;
    // one SCK edge per slot; even slot counts leave SCK low at phase end
    assign psram_sck_o = active && (slot_q[0] ^ (cyc_q >= hh));

    assign psram_io_en_o = (state_q == S_INST || state_q == S_ADDR ||
                            state_q == S_WDATA) ? 8'hFF : 8'h00;

    always_comb begin
        psram_io_out_o = 8'h00;
        unique case (state_q)
            S_INST: psram_io_out_o = cmd_q;
            S_ADDR: begin
                unique case (slot_q[1:0])
                    2'd0: psram_io_out_o = addr_q[31:24];
                    2'd1: psram_io_out_o = addr_q[23:16];
                    2'd2: psram_io_out_o = addr_q[15:8];
                    2'd3: psram_io_out_o = addr_q[7:0];
                endcase
            end
            // first slot cycle shows the byte being consumed right now
            S_WDATA: psram_io_out_o = (cyc_q == 4'd0) ?
                         (wdata_valid_i ? wdata_i : 8'h00) : wbyte_q;
            default: psram_io_out_o = 8'h00;
        endcase
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign err_o         = err_q;
    assign done_o        = (state_q == S_RECY) && (slot_q == SW'(RECY_CYC - 1));
    assign busy_o        = (state_q != S_IDLE);
    assign state_o       = state_q;

`ifdef PSRAM_DQS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dqs_q  <= '0;
            rcnt_q <= '0;
            tmo_q  <= '0;
        end else begin
            dqs_q  <= {dqs_q[1:0], psram_dqs_in_i};
            rcnt_q <= rcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign psram_dqs_en_o  = (state_q == S_WDATA);
    assign psram_dqs_out_o = 1'b0;
`else
    logic dqs_unused;
    assign dqs_unused      = psram_dqs_in_i;
    assign psram_dqs_en_o  = 1'b0;
    assign psram_dqs_out_o = 1'b0;
`endif

endmodule
